fast_pixel_ingress: RTL and testbench
=====================================

// Module: fast_pixel_ingress
// PURPOSE
//  Upstream stage of the FAST line-buffer window generator. Accepts an AXI4-Stream pixel stream from the ARM DMA
//  and drives the window generator's data_in/ce pair, one pixel per ce pulse. Repairs frame geometry by padding
//  short lines and short frames and truncating long lines. Every started frame yields exactly COL_NUM*ROW_NUM pulses,
//  so the downstream column/row counters never lose alignment.
// PARAMETERS
//  COL_NUM      640  pixels per line
//  ROW_NUM      480  lines per frame
//  PIXEL_WIDTH  8    pixel bit width
//  PAD_VALUE    0    pixel value emitted for padded positions
// PORTS
//  clk            in   1            clock
//  rst_n          in   1            asynchronous active-low reset
//  s_axis_tdata   in   PIXEL_WIDTH  input pixel
//  s_axis_tvalid  in   1            input beat valid
//  s_axis_tuser   in   1            start of frame (first pixel of frame)
//  s_axis_tlast   in   1            end of line (last pixel of line)
//  s_axis_tready  out  1            beat accepted when tvalid&&tready
//  pix_data       out  PIXEL_WIDTH  pixel to window generator data_in
//  pix_ce         out  1            pixel strobe to window generator ce
//  frame_done     out  1            1-cycle pulse coincident with the last pix_ce of a frame
//  err_short_line out  1            1-cycle pulse: tlast before column COL_NUM-1
//  err_long_line  out  1            1-cycle pulse: column COL_NUM-1 accepted without tlast
//  err_early_sof  out  1            1-cycle pulse: tuser received inside an unfinished frame
//  busy           out  1            high in every state except IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, col=0, row=0, hold register empty. All outputs 0 except s_axis_tready.
//    s_axis_tready=0 while rst_n=0 and 1 from the first clock after release.
//    Reset mid-frame aborts the frame with no padding.
//  - col/row hold the next position to emit. Widths are $clog2(COL_NUM) and $clog2(ROW_NUM).
//  - Every emission registers pix_data and sets pix_ce=1 for one cycle. Latency is 1 cycle from the accepting edge.
//    Emission advances col. At col==COL_NUM-1 it wraps col to 0 and increments row.
//    At (COL_NUM-1,ROW_NUM-1) it pulses frame_done, resets col/row to 0, and the frame is complete.
//  - s_axis_tready=1 in IDLE, ACTIVE and DROP_LINE. s_axis_tready=0 in PAD_LINE, PAD_FRAME and FLUSH_HOLD.
//  - IDLE: beats with tuser=0 are accepted and discarded. A tuser=1 beat is emitted at (0,0); next state ACTIVE.
//  - ACTIVE: for each beat, the first matching rule applies:
//     a) tuser=1: store the beat in the hold register, pulse err_early_sof, emit nothing this cycle; go PAD_FRAME.
//     b) col==COL_NUM-1: emit the pixel. If tlast=1, the line is correct.
//        If tlast=0, pulse err_long_line and go DROP_LINE.
//        If the frame completes and tlast=1, go IDLE.
//     c) tlast=1 (col<COL_NUM-1): emit the pixel, pulse err_short_line, go PAD_LINE.
//     d) otherwise: emit the pixel.
//  - PAD_LINE: emit PAD_VALUE once per cycle until col wraps to 0.
//    Next state is ACTIVE, or IDLE if the frame completed.
//  - DROP_LINE: accept and discard beats. A tlast beat is discarded and returns to ACTIVE, or IDLE if the frame completed.
//    A tuser=1 beat is handled as follows:
//     - frame complete: emit it at (0,0) and go ACTIVE.
//     - frame not complete: hold it, pulse err_early_sof and go PAD_FRAME.
//  - PAD_FRAME: emit PAD_VALUE once per cycle until the frame completes (frame_done pulses); then go FLUSH_HOLD.
//  - FLUSH_HOLD: emit the held pixel at (0,0), clear the hold register; go ACTIVE.
//  - No beat is accepted in a cycle where the FSM cannot emit or hold it.
//  - At most one error pulse per cycle; the precedence order of a)–c) applies.
//  - pix_ce never pulses twice for one position. pix_ce never pulses in IDLE unless a SOF is accepted.
// TESTING (bench parameters COL_NUM=8, ROW_NUM=4, PAD_VALUE=8'hEE)
//  1 Clean frame: 32 beats, tuser on beat 0, tlast every 8th beat, tvalid always 1
//    -> 32 pix_ce with data = input values, each 1 cycle after acceptance.
//    -> frame_done with the 32nd pix_ce; no error pulse; tready constantly 1.
//  2 Short line: row 1 tlast after 5 pixels -> err_short_line=1 once; 3 pixels of 8'hEE emitted with tready=0;
//    row 2 col 0 is the next input beat; total 32 pix_ce.
//  3 Long line: row 0 carries 11 pixels, tlast on the 11th -> err_long_line pulses when pixel 8 is accepted.
//    Pixels 9-11 are accepted but not emitted; row 1 aligns; total 32 pix_ce.
//  4 Early SOF: new tuser beat (data 8'h5A) arrives at row 2 col 3 -> err_early_sof=1; 13 pads of 8'hEE;
//    frame_done; then 8'h5A is emitted as (0,0) of the next frame.
//  5 Pre-SOF garbage plus backpressure: 5 beats with tuser=0 in IDLE -> discarded, no pix_ce.
//    Then a clean frame with tvalid toggling randomly -> 32 pix_ce in order.
//  6 Reset mid-frame: rst_n=0 at row 1 col 4 -> all outputs 0 immediately (asynchronously).
//    After release: IDLE, no padding; the next SOF frame is emitted cleanly.

Source files
------------

// File: rtl/fast_pixel_ingress.sv
// AXI4-Stream pixel ingress for the FAST window generator.
// Repairs line/frame geometry so each frame yields exactly COL_NUM*ROW_NUM strobes.
module fast_pixel_ingress #(
    parameter int                     COL_NUM     = 640,
    parameter int                     ROW_NUM     = 480,
    parameter int                     PIXEL_WIDTH = 8,
    parameter logic [PIXEL_WIDTH-1:0] PAD_VALUE   = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [PIXEL_WIDTH-1:0] pix_data,
    output logic                   pix_ce,
    output logic                   frame_done,
    output logic                   err_short_line,
    output logic                   err_long_line,
    output logic                   err_early_sof,
    output logic                   busy
);

    localparam int CW = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
    localparam int RW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(COL_NUM - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROW_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_PAD_LINE,
        S_DROP_LINE,
        S_PAD_FRAME,
        S_FLUSH_HOLD
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_col;
    logic [RW-1:0]          r_row;
    logic [PIXEL_WIDTH-1:0] r_hold_data;
    logic                   r_hold_vld;
    logic                   r_rdy_en;
    logic [PIXEL_WIDTH-1:0] r_pix_data;
    logic                   r_pix_ce;
    logic                   r_frame_done;
    logic                   r_err_short;
    logic                   r_err_long;
    logic                   r_err_sof;

    logic                   w_ready;
    logic                   w_acc;
    logic                   w_col_last;
    logic                   w_row_last;
    logic                   w_frame_end;
    logic                   w_at_origin;
    logic                   w_emit;
    logic [PIXEL_WIDTH-1:0] w_emit_data;
    logic                   w_hold_load;
    logic                   w_hold_clr;
    logic                   w_err_short;
    logic                   w_err_long;
    logic                   w_err_sof;

    assign w_ready = r_rdy_en &&
                     (r_state == S_IDLE || r_state == S_ACTIVE ||
                      r_state == S_DROP_LINE);
    assign w_acc       = s_axis_tvalid && w_ready;
    assign w_col_last  = (r_col == C_LAST);
    assign w_row_last  = (r_row == R_LAST);
    assign w_frame_end = w_col_last && w_row_last;
    // A dropped line always wraps row, so row 0 here means the frame finished
    assign w_at_origin = (r_col == '0) && (r_row == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_emit_data = s_axis_tdata;
        w_hold_load = 1'b0;
        w_hold_clr  = 1'b0;
        w_err_short = 1'b0;
        w_err_long  = 1'b0;
        w_err_sof   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc && s_axis_tuser) begin
                    w_emit      = 1'b1;
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_acc) begin
                    if (s_axis_tuser) begin
                        w_hold_load = 1'b1;
                        w_err_sof   = 1'b1;
                        w_state_nxt = S_PAD_FRAME;
                    end else if (w_col_last) begin
                        w_emit = 1'b1;
                        if (!s_axis_tlast) begin
                            w_err_long  = 1'b1;
                            w_state_nxt = S_DROP_LINE;
                        end else if (w_row_last) begin
                            w_state_nxt = S_IDLE;
                        end
                    end else if (s_axis_tlast) begin
                        w_emit      = 1'b1;
                        w_err_short = 1'b1;
                        w_state_nxt = S_PAD_LINE;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
            end
            S_PAD_LINE: begin
                w_emit      = 1'b1;
                w_emit_data = PAD_VALUE;
                if (w_col_last) begin
                    w_state_nxt = w_row_last ? S_IDLE : S_ACTIVE;
                end
            end
            S_DROP_LINE: begin
                if (w_acc) begin
                    if (s_axis_tuser) begin
                        if (w_at_origin) begin
                            w_emit      = 1'b1;
                            w_state_nxt = S_ACTIVE;
                        end else begin
                            w_hold_load = 1'b1;
                            w_err_sof   = 1'b1;
                            w_state_nxt = S_PAD_FRAME;
                        end
                    end else if (s_axis_tlast) begin
                        w_state_nxt = w_at_origin ? S_IDLE : S_ACTIVE;
                    end
                end
            end
            S_PAD_FRAME: begin
                w_emit      = 1'b1;
                w_emit_data = PAD_VALUE;
                if (w_frame_end) begin
                    w_state_nxt = S_FLUSH_HOLD;
                end
            end
            S_FLUSH_HOLD: begin
                w_emit      = r_hold_vld;
                w_emit_data = r_hold_data;
                w_hold_clr  = 1'b1;
                w_state_nxt = S_ACTIVE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rdy_en <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_emit) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_data <= '0;
            r_hold_vld  <= 1'b0;
        end else if (w_hold_load) begin
            r_hold_data <= s_axis_tdata;
            r_hold_vld  <= 1'b1;
        end else if (w_hold_clr) begin
            r_hold_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_data   <= '0;
            r_pix_ce     <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
            r_err_sof    <= 1'b0;
        end else begin
            if (w_emit) begin
                r_pix_data <= w_emit_data;
            end
            r_pix_ce     <= w_emit;
            r_frame_done <= w_emit && w_frame_end;
            r_err_short  <= w_err_short;
            r_err_long   <= w_err_long;
            r_err_sof    <= w_err_sof;
        end
    end

    assign s_axis_tready  = w_ready;
    assign pix_data       = r_pix_data;
    assign pix_ce         = r_pix_ce;
    assign frame_done     = r_frame_done;
    assign err_short_line = r_err_short;
    assign err_long_line  = r_err_long;
    assign err_early_sof  = r_err_sof;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_fast_pixel_ingress.sv
// Bench for fast_pixel_ingress: random beats against a position/pad-count model,
// plus per-scenario literal counts.
module tb_fast_pixel_ingress;

    localparam int C = 8;
    localparam int R = 4;
    localparam int N = C * R;
    localparam logic [7:0] PAD = 8'hEE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tuser = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tready;
    logic [7:0] pix_data;
    logic       pix_ce;
    logic       frame_done;
    logic       err_short_line;
    logic       err_long_line;
    logic       err_early_sof;
    logic       busy;

    always #5 clk = ~clk;

    fast_pixel_ingress #(
        .COL_NUM    (C),
        .ROW_NUM    (R),
        .PIXEL_WIDTH(8),
        .PAD_VALUE  (PAD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .pix_data      (pix_data),
        .pix_ce        (pix_ce),
        .frame_done    (frame_done),
        .err_short_line(err_short_line),
        .err_long_line (err_long_line),
        .err_early_sof (err_early_sof),
        .busy          (busy)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       u;
        logic       l;
    } beat_t;

    beat_t q[$];

    int compared = 0;
    int mismatched = 0;

    // Model: linear position in frame, pending pad count, held SOF pixel
    int         m_pos = 0;
    int         m_pad = 0;
    bit         m_inframe = 0;
    bit         m_drop = 0;
    bit         m_held = 0;
    bit         m_inrdy = 0;
    bit         m_acc = 0;
    int         m_col = 0;
    logic [7:0] m_hold = '0;
    logic       e_ce = 0, e_done = 0, e_short = 0, e_long = 0, e_sof = 0;
    logic       e_rdy = 0, e_busy = 0;
    logic [7:0] e_data = '0;

    task automatic m_emit(input logic [7:0] d);
        e_ce = 1;
        e_data = d;
        if (m_pos == N - 1) begin
            e_done = 1;
            m_pos = 0;
            m_inframe = 0;
        end else begin
            m_pos++;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_pad = 0; m_inframe = 0; m_drop = 0;
            m_held = 0; m_inrdy = 0;
            e_ce = 0; e_done = 0; e_short = 0; e_long = 0; e_sof = 0;
        end else begin
            m_acc = s_axis_tvalid && e_rdy;
            e_ce = 0; e_done = 0; e_short = 0; e_long = 0; e_sof = 0;
            if (m_pad > 0) begin
                m_pad--;
                m_emit(PAD);
            end else if (m_held) begin
                m_held = 0;
                m_inframe = 1;
                m_emit(m_hold);
            end else if (m_acc) begin
                m_col = m_pos % C;
                if (s_axis_tuser) begin
                    if (m_inframe) begin
                        m_hold = s_axis_tdata;
                        m_held = 1;
                        m_pad = N - m_pos;
                        e_sof = 1;
                    end else begin
                        m_inframe = 1;
                        m_emit(s_axis_tdata);
                    end
                    m_drop = 0;
                end else if (m_drop) begin
                    if (s_axis_tlast) m_drop = 0;
                end else if (m_inframe) begin
                    if (m_col == C - 1) begin
                        if (!s_axis_tlast) begin
                            e_long = 1;
                            m_drop = 1;
                        end
                    end else if (s_axis_tlast) begin
                        e_short = 1;
                        m_pad = C - 1 - m_col;
                    end
                    m_emit(s_axis_tdata);
                end
            end
            m_inrdy = 1;
        end
        e_rdy  = m_inrdy && m_pad == 0 && !m_held;
        e_busy = m_inframe || m_drop || m_pad > 0 || m_held;
    end

    int         n_ce, n_done, n_short, n_long, n_sof, n_pad, n_nrdy;
    logic [7:0] first_after = '0;
    bit         prev_done = 0;

    always @(negedge clk) begin
        compared++;
        if (pix_ce !== e_ce || frame_done !== e_done ||
            err_short_line !== e_short || err_long_line !== e_long ||
            err_early_sof !== e_sof || s_axis_tready !== e_rdy ||
            busy !== e_busy || (e_ce && pix_data !== e_data)) begin
            mismatched++;
            $display("FAIL cycle t=%0t got/want ce=%b/%b done=%b/%b sh=%b/%b lo=%b/%b sof=%b/%b rdy=%b/%b busy=%b/%b data=%h/%h",
                     $time, pix_ce, e_ce, frame_done, e_done,
                     err_short_line, e_short, err_long_line, e_long,
                     err_early_sof, e_sof, s_axis_tready, e_rdy,
                     busy, e_busy, pix_data, e_data);
        end
        if (pix_ce) n_ce++;
        if (frame_done) n_done++;
        if (err_short_line) n_short++;
        if (err_long_line) n_long++;
        if (err_early_sof) n_sof++;
        if (pix_ce && pix_data == PAD) n_pad++;
        if (rst_n && !s_axis_tready) n_nrdy++;
        if (prev_done && pix_ce) first_after = pix_data;
        prev_done = frame_done;
    end

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        n_ce = 0; n_done = 0; n_short = 0; n_long = 0;
        n_sof = 0; n_pad = 0; n_nrdy = 0;
    endtask

    task automatic push_line(input int len, input bit sof, input bit last);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = 8'($urandom_range(0, 237));
            b.u = sof && (i == 0);
            b.l = last && (i == len - 1);
            q.push_back(b);
        end
    endtask

    task automatic push_frame();
        push_line(C, 1, 1);
        for (int i = 1; i < R; i++) push_line(C, 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rand_valid);
        int budget;
        bit acc;
        budget = 2000;
        while (q.size() > 0) begin
            if (budget == 0) begin
                chk("drive_timeout", q.size(), 0);
                q.delete();
                break;
            end
            budget--;
            if (rand_valid && $urandom_range(0, 2) == 0) begin
                s_axis_tvalid = 0;
            end else begin
                s_axis_tvalid = 1;
                s_axis_tdata  = q[0].d;
                s_axis_tuser  = q[0].u;
                s_axis_tlast  = q[0].l;
            end
            @(negedge clk);
            acc = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            #1;
            if (acc) void'(q.pop_front());
        end
        s_axis_tvalid = 0;
        s_axis_tuser  = 0;
        s_axis_tlast  = 0;
    endtask

    initial begin
        #2 rst_n = 0;
        @(posedge clk); #1;
        chk("reset_outputs", int'({pix_ce, frame_done, err_short_line,
            err_long_line, err_early_sof, busy, s_axis_tready}), 0);
        @(posedge clk); #1;
        rst_n = 1;
        chk("tready_at_release", int'(s_axis_tready), 0);
        @(posedge clk); #1;
        chk("tready_after_clk", int'(s_axis_tready), 1);

        // 1 clean frame
        clr();
        push_frame();
        drive(0);
        idle(10);
        chk("t1_ce", n_ce, 32);
        chk("t1_done", n_done, 1);
        chk("t1_errs", n_short + n_long + n_sof, 0);
        chk("t1_nrdy", n_nrdy, 0);

        // 2 short line in row 1
        clr();
        push_line(C, 1, 1);
        push_line(5, 0, 1);
        push_line(C, 0, 1);
        push_line(C, 0, 1);
        drive(0);
        idle(10);
        chk("t2_ce", n_ce, 32);
        chk("t2_short", n_short, 1);
        chk("t2_pad", n_pad, 3);
        chk("t2_nrdy", n_nrdy, 3);

        // 3 long line in row 0
        clr();
        push_line(11, 1, 1);
        for (int i = 1; i < R; i++) push_line(C, 0, 1);
        drive(0);
        idle(10);
        chk("t3_ce", n_ce, 32);
        chk("t3_long", n_long, 1);
        chk("t3_done", n_done, 1);

        // 4 early SOF at row 2 col 3
        clr();
        push_line(C, 1, 1);
        push_line(C, 0, 1);
        push_line(3, 0, 0);
        push_frame();
        q[19].d = 8'h5A;
        drive(0);
        idle(10);
        chk("t4_sof", n_sof, 1);
        chk("t4_pad", n_pad, 13);
        chk("t4_ce", n_ce, 64);
        chk("t4_done", n_done, 2);
        chk("t4_first", int'(first_after), 'h5A);

        // 5 pre-SOF garbage then frame with random tvalid
        clr();
        push_line(5, 0, 0);
        drive(1);
        idle(3);
        chk("t5_garbage_ce", n_ce, 0);
        chk("t5_garbage_busy", int'(busy), 0);
        push_frame();
        drive(1);
        idle(10);
        chk("t5_ce", n_ce, 32);
        chk("t5_done", n_done, 1);

        // 6 reset mid-frame at row 1 col 4
        clr();
        push_line(C, 1, 1);
        push_line(4, 0, 0);
        drive(0);
        chk("t6_busy_before", int'(busy), 1);
        #2 rst_n = 0;
        #1;
        chk("t6_async_out", int'({pix_ce, frame_done, err_short_line,
            err_long_line, err_early_sof, busy, s_axis_tready, pix_data}), 0);
        idle(3);
        rst_n = 1;
        idle(2);
        clr();
        idle(10);
        chk("t6_no_pad", n_ce, 0);
        push_frame();
        drive(0);
        idle(10);
        chk("t6_ce", n_ce, 32);
        chk("t6_done", n_done, 1);
        chk("t6_pad", n_pad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
